ship_input_ctrl: RTL and testbench



---
 rtl/ship_input_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ship_input_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ship_input_ctrl.sv
// ship_input_ctrl: upstream control stage for the colour/sprite mapper.
// Turns the raw USB keycode into a sticky one-hot ship direction, a moving flag and a
// handshaked single-bullet fire request. All state advances only on sys_clk edges where
// frame_tick is high (one tick per frame).
//
// Ports:
//   sys_clk        in   system clock
//   reset_n        in   asynchronous active-low reset
//   frame_tick     in   one-cycle pulse per frame; every high cycle counts as one tick
//   keycode[7:0]   in   current USB keycode, 8'h00 = no key
//   bullets_exist  in   bullet pair in flight (from the bullet stage)
//   direction[3:0] out  {up,down,right,left}, one-hot
//   moving         out  ship has started moving (sticky until reset)
//   shoot          out  fire request to the bullet stage (level)
//   fire_busy      out  fire FSM is not idle
//
// Build option: define SHIP_AUTOFIRE_EN to keep the fire path permanently armed, so a
// held fire key re-requests every time the cooldown completes.
module ship_input_ctrl #(
  parameter logic [7:0]  KEY_UP          = 8'h1A,
  parameter logic [7:0]  KEY_DOWN        = 8'h16,
  parameter logic [7:0]  KEY_LEFT        = 8'h04,
  parameter logic [7:0]  KEY_RIGHT       = 8'h07,
  parameter logic [7:0]  KEY_FIRE        = 8'h2C,
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned FIRE_COOLDOWN   = 8,
  parameter int unsigned ACK_TIMEOUT     = 4
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       bullets_exist,
  output logic [3:0] direction,
  output logic       moving,
  output logic       shoot,
  output logic       fire_busy
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitClear, StCooldown} fire_state_e;

  localparam logic [3:0] DebMax   = 4'(DEBOUNCE_FRAMES);
  localparam logic [7:0] CoolLoad = 8'(FIRE_COOLDOWN);
  localparam logic [7:0] AckLoad  = 8'(ACK_TIMEOUT);

  // Debounce
  logic [7:0] sample_q, sample_d;
  logic [3:0] stable_q, stable_d;
  logic [7:0] deb_q, deb_d;
  logic       accept;

  always_comb begin
    sample_d = sample_q;
    stable_d = stable_q;
    deb_d    = deb_q;
    accept   = 1'b0;
    if (frame_tick) begin
      if (keycode != sample_q) begin
        sample_d = keycode;
        stable_d = 4'd1;
        accept   = (DebMax == 4'd1);
      end else if (stable_q != DebMax) begin
        stable_d = stable_q + 4'd1;
        accept   = ((stable_q + 4'd1) == DebMax);
      end
      if (accept) begin
        deb_d = keycode;
      end
    end
  end

  // Direction: only an accepted direction key changes it; everything else is sticky.
  logic [3:0] direction_q, direction_d;
  logic       moving_q, moving_d;
  logic [3:0] dir_hit;

  assign dir_hit = {keycode == KEY_UP, keycode == KEY_DOWN,
                    keycode == KEY_RIGHT, keycode == KEY_LEFT};

  always_comb begin
    direction_d = direction_q;
    moving_d    = moving_q;
    if (accept && (dir_hit != 4'b0000)) begin
      direction_d = dir_hit;
      moving_d    = 1'b1;
    end
  end

  // Fire FSM. fire_pressed is a level on the debounced key (post-update), so the armed
  // flag is what limits a held key to a single request.
  fire_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fire_pressed;
  logic        fire_armed;
  logic        fire_start;

  assign fire_pressed = (deb_d == KEY_FIRE);
  assign fire_start   = frame_tick && (state_q == StIdle) && fire_pressed && fire_armed &&
                        !bullets_exist;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_tick) begin
      unique case (state_q)
        StIdle: begin
          if (fire_start) begin
            state_d = StReq;
            cnt_d   = AckLoad;
          end
        end
        StReq: begin
          if (bullets_exist) begin
            state_d = StWaitClear;
          end else if (cnt_q <= 8'd1) begin
            // Request never acknowledged: drop it without a cooldown.
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StWaitClear: begin
          if (!bullets_exist) begin
            if (CoolLoad == 8'd0) begin
              state_d = StIdle;
            end else begin
              state_d = StCooldown;
              cnt_d   = CoolLoad;
            end
          end
        end
        StCooldown: begin
          if (cnt_q <= 8'd1) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef SHIP_AUTOFIRE_EN
  assign fire_armed = 1'b1;
`else
  logic armed_q;

  // Re-arm only once the debounced key is no longer fire: one shot per press.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q <= 1'b1;
    end else if (frame_tick) begin
      if (fire_start) begin
        armed_q <= 1'b0;
      end else if (!fire_pressed) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign fire_armed = armed_q;
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q    <= 8'h00;
      stable_q    <= 4'd0;
      deb_q       <= 8'h00;
      direction_q <= 4'b1000;
      moving_q    <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
    end else begin
      sample_q    <= sample_d;
      stable_q    <= stable_d;
      deb_q       <= deb_d;
      direction_q <= direction_d;
      moving_q    <= moving_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  // shoot decodes straight from the state flop so the async clear drops it immediately.
  assign direction = direction_q;
  assign moving    = moving_q;
  assign shoot     = (state_q == StReq);
  assign fire_busy = (state_q != StIdle);

endmodule

// File: tb/tb_ship_input_ctrl.sv
// Directed testbench for ship_input_ctrl with hand-computed expectations.
module tb_ship_input_ctrl;

  logic       sys_clk;
  logic       reset_n;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       bullets_exist;
  logic [3:0] direction;
  logic       moving;
  logic       shoot;
  logic       fire_busy;

  int n_total = 0;
  int n_bad   = 0;

  ship_input_ctrl dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .keycode       (keycode),
    .bullets_exist (bullets_exist),
    .direction     (direction),
    .moving        (moving),
    .shoot         (shoot),
    .fire_busy     (fire_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame tick: a single high cycle, returns at the following negedge.
  task automatic do_tick();
    @(negedge sys_clk);
    frame_tick = 1'b1;
    @(negedge sys_clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  int pulses;
  int life;
  logic prev_shoot;

  // Minimal bullet stage: acknowledge a request, keep bullets alive a few ticks.
  task automatic bullet_tick();
    do_tick();
    if (shoot && !prev_shoot) pulses++;
    prev_shoot = shoot;
    if (shoot) begin
      bullets_exist = 1'b1;
      life = 3;
    end else if (life > 0) begin
      life--;
      if (life == 0) bullets_exist = 1'b0;
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    frame_tick    = 1'b0;
    keycode       = 8'h00;
    bullets_exist = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    @(negedge sys_clk);

    check("rst_dir", 32'(direction), 32'h8);
    check("rst_moving", 32'(moving), 32'h0);
    check("rst_shoot", 32'(shoot), 32'h0);
    check("rst_busy", 32'(fire_busy), 32'h0);

    // No tick, no change
    keycode = 8'h07;
    repeat (5) @(negedge sys_clk);
    check("no_tick_dir", 32'(direction), 32'h8);

    // Test 1: right key accepted on tick 2
    do_tick();
    check("t1_tick1_dir", 32'(direction), 32'h8);
    check("t1_tick1_moving", 32'(moving), 32'h0);
    do_tick();
    check("t1_tick2_dir", 32'(direction), 32'h2);
    check("t1_tick2_moving", 32'(moving), 32'h1);
    keycode = 8'h00;
    do_ticks(3);
    check("t1_release_dir", 32'(direction), 32'h2);

    // Test 2: keycode changing every tick is never accepted
    for (int i = 0; i < 10; i++) begin
      keycode = (i % 2 == 0) ? 8'h1A : 8'h16;
      do_tick();
    end
    check("t2_toggle_dir", 32'(direction), 32'h2);
    check("t2_toggle_moving", 32'(moving), 32'h1);

    // Reversals
    keycode = 8'h04;
    do_tick();
    check("rev_left_t1", 32'(direction), 32'h2);
    do_tick();
    check("rev_left_t2", 32'(direction), 32'h1);
    keycode = 8'h07;
    do_ticks(2);
    check("rev_right", 32'(direction), 32'h2);

    // frame_tick held high two cycles = two ticks
    @(negedge sys_clk);
    keycode    = 8'h16;
    frame_tick = 1'b1;
    @(negedge sys_clk);
    check("held_tick_1", 32'(direction), 32'h2);
    @(negedge sys_clk);
    frame_tick = 1'b0;
    check("held_tick_2", 32'(direction), 32'h4);

    // Test 3: full shot cycle with cooldown
    keycode = 8'h2C;
    do_tick();
    check("t3_tick1_shoot", 32'(shoot), 32'h0);
    do_tick();
    check("t3_tick2_shoot", 32'(shoot), 32'h1);
    check("t3_tick2_busy", 32'(fire_busy), 32'h1);
    check("t3_fire_keeps_dir", 32'(direction), 32'h4);
    do_tick();
    check("t3_tick3_shoot", 32'(shoot), 32'h1);
    bullets_exist = 1'b1;
    do_tick();
    check("t3_ack_shoot", 32'(shoot), 32'h0);
    check("t3_ack_busy", 32'(fire_busy), 32'h1);
    do_ticks(15);
    check("t3_wait_busy", 32'(fire_busy), 32'h1);
    check("t3_wait_shoot", 32'(shoot), 32'h0);
    bullets_exist = 1'b0;
    for (int t = 20; t < 28; t++) begin
      do_tick();
      check($sformatf("t3_cool_busy_%0d", t), 32'(fire_busy), 32'h1);
    end
    do_tick();
    check("t3_idle_busy", 32'(fire_busy), 32'h0);
    check("t3_idle_shoot", 32'(shoot), 32'h0);
    keycode = 8'h00;
    do_ticks(12);
    check("t3_release_busy", 32'(fire_busy), 32'h0);

    // Test 4: request never acknowledged -> 4 ticks of shoot, no cooldown
    keycode = 8'h2C;
    do_tick();
    for (int t = 2; t <= 5; t++) begin
      do_tick();
      check($sformatf("t4_shoot_%0d", t), 32'(shoot), 32'h1);
    end
    do_tick();
    check("t4_drop_shoot", 32'(shoot), 32'h0);
    check("t4_drop_busy", 32'(fire_busy), 32'h0);
    do_tick();
    check("t4_no_cool_busy", 32'(fire_busy), 32'h0);
    keycode = 8'h00;
    do_ticks(2);

    // Foreign bullet while idle is ignored
    bullets_exist = 1'b1;
    do_ticks(2);
    check("foreign_busy", 32'(fire_busy), 32'h0);
    bullets_exist = 1'b0;

    // Test 5: hold fire 40 ticks across a full shot cycle
    pulses     = 0;
    life       = 0;
    prev_shoot = 1'b0;
    keycode    = 8'h2C;
    for (int i = 0; i < 40; i++) bullet_tick();
`ifdef SHIP_AUTOFIRE_EN
    check("t5_multi_pulse", 32'(pulses >= 2), 32'h1);
`else
    check("t5_pulses", 32'(pulses), 32'h1);
`endif
    keycode = 8'h00;
    for (int i = 0; i < 25; i++) bullet_tick();
    check("t5_settle_busy", 32'(fire_busy), 32'h0);
    bullets_exist = 1'b0;

    // Test 6: async reset while shoot is high
    keycode = 8'h2C;
    do_ticks(2);
    check("t6_pre_shoot", 32'(shoot), 32'h1);
    check("t6_pre_moving", 32'(moving), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_shoot", 32'(shoot), 32'h0);
    check("t6_async_moving", 32'(moving), 32'h0);
    check("t6_async_busy", 32'(fire_busy), 32'h0);
    check("t6_async_dir", 32'(direction), 32'h8);
    @(negedge sys_clk);
    reset_n = 1'b1;
    do_ticks(2);
    check("t6_rearm_shoot", 32'(shoot), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
